// File: rtl/imem_icache_if.sv
// Instruction-fetch, backing-memory and statistics signals of the instruction cache.
// The cache takes the slave view; the core/memory side takes the master view.
interface imem_icache_if;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  modport master (
    output imem_addr, imem_rd, flush, mem_rdata, mem_valid,
    input  imem_rdata, imem_ready, mem_req, mem_addr, hit_count, miss_count
  );

  modport slave (
    input  imem_addr, imem_rd, flush, mem_rdata, mem_valid,
    output imem_rdata, imem_ready, mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/imem_icache.sv
// Direct-mapped read-only instruction cache: combinational hits, word-by-word line refill
// from backing memory on a miss, saturating hit/miss statistics.
module imem_icache #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input logic          clk,
  input logic          rst_n,
  imem_icache_if.slave bus
);
  localparam int unsigned OW = $clog2(WORDS);
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 32 - 2 - OW - IW;

  typedef enum logic {StIdle, StRefill} state_e;

  state_e            state;
  logic [LINES-1:0]  valid;
  logic [TW-1:0]     tags [LINES];
  logic [31:0]       data [LINES*WORDS];
  logic [TW-1:0]     refill_tag;
  logic [IW-1:0]     refill_idx;
  logic [OW-1:0]     beat;
  logic              flush_pend;

  logic [TW-1:0]     req_tag;
  logic [IW-1:0]     req_idx;
  logic [OW-1:0]     req_off;
  logic              hit;
  logic              unused_addr;

  assign req_off     = bus.imem_addr[2 +: OW];
  assign req_idx     = bus.imem_addr[2+OW +: IW];
  assign req_tag     = bus.imem_addr[31 -: TW];
  assign unused_addr = ^bus.imem_addr[1:0];

  assign hit            = (state == StIdle) && bus.imem_rd && valid[req_idx] &&
                          (tags[req_idx] == req_tag);
  assign bus.imem_ready = hit;
  assign bus.imem_rdata = hit ? data[{req_idx, req_off}] : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= StIdle;
      valid          <= '0;
      beat           <= '0;
      flush_pend     <= 1'b0;
      refill_tag     <= '0;
      refill_idx     <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_addr   <= 32'h0;
      bus.hit_count  <= 16'h0;
      bus.miss_count <= 16'h0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.imem_rd) begin
            if (hit) begin
              if (bus.hit_count != 16'hFFFF) bus.hit_count <= bus.hit_count + 16'd1;
            end else begin
              if (bus.miss_count != 16'hFFFF) bus.miss_count <= bus.miss_count + 16'd1;
              refill_tag   <= req_tag;
              refill_idx   <= req_idx;
              beat         <= '0;
              state        <= StRefill;
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= {req_tag, req_idx, {OW{1'b0}}, 2'b00};
            end
          end
          // The lookup above already used the pre-flush valids.
          if (bus.flush) valid <= '0;
        end

        StRefill: begin
          if (bus.flush) begin
            valid      <= '0;
            flush_pend <= 1'b1;
          end
          if (bus.mem_valid) begin
            data[{refill_idx, beat}] <= bus.mem_rdata;
            beat                     <= beat + 1'b1;
            if (beat == OW'(WORDS - 1)) begin
              tags[refill_idx] <= refill_tag;
              // A flush seen at any point in the burst leaves the refilled line invalid.
              if (!flush_pend && !bus.flush) valid[refill_idx] <= 1'b1;
              flush_pend  <= 1'b0;
              state       <= StIdle;
              bus.mem_req <= 1'b0;
            end else begin
              bus.mem_addr <= {refill_tag, refill_idx, beat + 1'b1, 2'b00};
            end
          end
        end

        default: state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_icache.sv
// Randomized scoreboard bench for imem_icache against a line-level behavioural model
// with an independent backing-memory responder.
module tb_imem_icache;
  localparam int unsigned LINES      = 16;
  localparam int unsigned WORDS      = 4;
  localparam int unsigned LINE_BYTES = WORDS * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  imem_icache_if bus ();

  imem_icache #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q [$];
  logic        stim_flush = 1'b0;
  logic        resp_flush;
  logic        stray = 1'b0;
  int          wait_mode = 0;
  logic [31:0] cur_line = 32'h0;
  int unsigned beats_seen = 0;
  int unsigned waits_seen = 0;
  int          burst_cnt = 0;
  int          flush_burst = -1;

  bit          mvalid [LINES];
  int unsigned mtag   [LINES];
  int unsigned mhits;
  int unsigned mmiss;

  assign bus.flush = stim_flush | resp_flush;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + (a >> 2) + (a >> 4) * 32'h0101_0000;
  endfunction

  function automatic int pick_wait();
    if (wait_mode < 0) return int'($urandom_range(0, 2));
    return wait_mode;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  task automatic check_counters();
    check("hit_count", 32'(bus.hit_count), mhits);
    check("miss_count", 32'(bus.miss_count), mmiss);
  endtask

  // Backing memory: answers each requested word after a configurable wait.
  initial begin : responder
    int wait_left;
    int beat;
    bit in_burst;
    wait_left     = 0;
    beat          = 0;
    in_burst      = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 32'h0;
    resp_flush    = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_valid = 1'b0;
      resp_flush    = 1'b0;
      if (!rst_n) begin
        in_burst = 1'b0;
        beat     = 0;
      end else if (bus.mem_req) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          beat     = 0;
          burst_cnt++;
          wait_left = pick_wait();
        end
        if (wait_left > 0) begin
          wait_left--;
          waits_seen++;
        end else begin
          check("mem_addr", bus.mem_addr, cur_line + 32'(beat * 4));
          bus.mem_valid = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_addr);
          if (burst_cnt == flush_burst && beat == 1) resp_flush = 1'b1;
          beats_seen++;
          beat++;
          if (beat == WORDS) in_burst = 1'b0;
          else wait_left = pick_wait();
        end
      end else if (stray) begin
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: every ready cycle must match the oldest outstanding fetch.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.imem_ready) begin
          if (exp_q.size() == 0) check("ready_unexpected", 32'(bus.imem_ready), 32'd0);
          else check("imem_rdata", bus.imem_rdata, exp_q.pop_front());
        end else begin
          check("rdata_not_ready", bus.imem_rdata, 32'h0);
        end
      end
    end
  end

  // Holds the fetch until ready, like a stalled IF stage, then updates the model.
  task automatic fetch(input logic [31:0] a, input bit flush_mid);
    int unsigned idx, tg, refills, n, b0, w0;
    bit hit;
    @(posedge clk);
    #1;
    check_counters();
    idx     = (a / LINE_BYTES) % LINES;
    tg      = a / (LINE_BYTES * LINES);
    hit     = mvalid[idx] && (mtag[idx] == tg);
    refills = hit ? 0 : (flush_mid ? 2 : 1);
    if (!hit && flush_mid) flush_burst = burst_cnt + 1;
    cur_line = a & ~32'(LINE_BYTES - 1);
    b0 = beats_seen;
    w0 = waits_seen;
    exp_q.push_back(mem_word(a & ~32'h3));
    bus.imem_addr = a;
    bus.imem_rd   = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.imem_ready) break;
      n++;
      if (n > 200) begin
        miscompares++;
        vectors++;
        $display("FAIL fetch_timeout: addr %h no ready after %0d cycles", a, n);
        summary();
        $finish;
      end
      @(posedge clk);
      #1;
    end
    check("fetch_latency", n, refills * (WORDS + 1) + (waits_seen - w0));
    check("refill_beats", beats_seen - b0, refills * WORDS);
    if (refills == 2) model_clear();
    mvalid[idx] = 1'b1;
    mtag[idx]   = tg;
    if (mhits < 65535) mhits++;
    mmiss = (mmiss + refills > 65535) ? 65535 : mmiss + refills;
  endtask

  task automatic flush_idle();
    @(posedge clk);
    #1;
    check_counters();
    bus.imem_rd = 1'b0;
    stim_flush  = 1'b1;
    @(posedge clk);
    #1;
    stim_flush = 1'b0;
    model_clear();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [3:0] t, i, o;
    t = 4'($urandom_range(0, 2));
    i = 4'($urandom_range(0, 15));
    o = 4'($urandom_range(0, 15));
    return {20'h0, t, i, o};
  endfunction

  initial begin : watchdog
    #5_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  initial begin : stimulus
    int n;
    bus.imem_addr = 32'h0;
    bus.imem_rd   = 1'b0;
    mhits = 0;
    mmiss = 0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(bus.imem_ready), 32'd0);
    check("reset_rdata", bus.imem_rdata, 32'h0);
    check("reset_mem_req", 32'(bus.mem_req), 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'h0);
    check_counters();

    // Directed: cold miss, sequential hits, conflict misses.
    wait_mode = 0;
    fetch(32'h0000_0000, 1'b0);
    fetch(32'h0000_0004, 1'b0);
    fetch(32'h0000_0008, 1'b0);
    fetch(32'h0000_000C, 1'b0);
    fetch(32'h0000_0100, 1'b0);
    fetch(32'h0000_0000, 1'b0);

    // Flush arriving on the second beat of a slow refill.
    wait_mode = 2;
    fetch(32'h0000_0040, 1'b1);

    wait_mode = -1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) flush_idle();
      else fetch(rand_addr(), ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a refill.
    wait_mode = 0;
    fetch(32'h0000_0050, 1'b0);
    @(posedge clk);
    #1;
    check_counters();
    cur_line      = 32'h0000_0760;
    bus.imem_addr = 32'h0000_0764;
    bus.imem_rd   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_req && n < 10);
    check("abort_req_seen", 32'(bus.mem_req), 32'd1);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    bus.imem_rd = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_mem_req", 32'(bus.mem_req), 32'd0);
    mhits = 0;
    mmiss = 0;
    model_clear();
    check_counters();
    @(posedge clk);
    #1;
    stray = 1'b1;
    @(posedge clk);
    #1;
    stray = 1'b0;
    @(negedge clk);
    check("stray_mem_req", 32'(bus.mem_req), 32'd0);
    fetch(32'h0000_0050, 1'b0);

    // Drive the hit counter into saturation, then one hit beyond.
    while (mhits < 65535) fetch(32'h0000_0054, 1'b0);
    fetch(32'h0000_0058, 1'b0);
    @(posedge clk);
    #1;
    bus.imem_rd = 1'b0;
    check_counters();
    check("hit_count_sat", 32'(bus.hit_count), 32'h0000_FFFF);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    summary();
    $finish;
  end
endmodule
